// File: rtl/ixc_sample_pkg.sv
// Shared types and constants for the sampled-vector change-capture stage.
package ixc_sample_pkg;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_DEPTH  = 16;
  localparam int DEF_TS_W   = 16;
  localparam int DEF_DROP_W = 8;

  localparam int REC_W = DEF_TS_W + DEF_WIDTH;

  // Wide all-ones; each instance slices it down to its own counter width.
  localparam logic [31:0] DROP_SAT = '1;

  typedef struct packed {
    logic [DEF_TS_W-1:0]  ts;
    logic [DEF_WIDTH-1:0] val;
  } rec_t;

endpackage

// File: rtl/ixc_sample_fifo.sv
// Synchronous first-word-fall-through FIFO with a registered head-of-queue
// output; pointers carry an extra MSB to tell full from empty.
module ixc_sample_fifo #(
  parameter int DW    = 24,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       srst,
  input  logic                       push,
  input  logic [DW-1:0]              push_data,
  input  logic                       pop,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level,
  output logic [DW-1:0]              rd_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [LW-1:0] wr_ptr_q, wr_ptr_d;
  logic [LW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_d;
  logic [DW-1:0] head_q;
  logic          push_ok;
  logic          pop_ok;
  logic          bypass;

  assign level   = wr_ptr_q - rd_ptr_q;
  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign rd_data = head_q;

  always_comb begin
    pop_ok   = pop && !empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    push_ok  = push && (!full || pop_ok);
    wr_ptr_d = wr_ptr_q + LW'(push_ok);
    rd_ptr_d = rd_ptr_q + LW'(pop_ok);
    level_d  = wr_ptr_d - rd_ptr_d;
    // The new head is the word being written now, so RAM does not hold it yet.
    bypass   = push_ok && (rd_ptr_d == wr_ptr_q);
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_q[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (level_d != '0) begin
        head_q <= bypass ? push_data : mem[rd_ptr_d[AW-1:0]];
      end
    end
  end

endmodule

// File: rtl/ixc_sample_chg_capture.sv
// Change detector on the sampled vector: each change (or the first enabled
// cycle) is tagged with a free-running timestamp and queued for upload.
module ixc_sample_chg_capture
  import ixc_sample_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int TS_W   = DEF_TS_W,
  parameter int DROP_W = DEF_DROP_W
) (
  input  logic                    fclk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [WIDTH-1:0]        sv,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [TS_W+WIDTH-1:0]   out_data,
  output logic                    overflow,
  output logic [DROP_W-1:0]       drop_cnt,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int RW = TS_W + WIDTH;
  localparam logic [DROP_W-1:0] SAT = DROP_SAT[DROP_W-1:0];

  logic [TS_W-1:0]   ts_q, ts_d;
  logic [WIDTH-1:0]  prev_q, prev_d;
  logic              primed_q, primed_d;
  logic              overflow_q, overflow_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic              capture;
  logic              pop;
  logic              drop;
  logic              fifo_full;
  logic              fifo_empty;

  always_comb begin
    capture    = en && (!primed_q || (sv != prev_q));
    pop        = out_valid && out_ready;
    drop       = capture && fifo_full && !pop;
    ts_d       = ts_q + TS_W'(1);
    // prev follows sv even when the record is dropped.
    prev_d     = en ? sv : prev_q;
    primed_d   = en;
    overflow_d = overflow_q || drop;
    drop_d     = drop_q;
    if (drop && (drop_q != SAT)) begin
      drop_d = drop_q + DROP_W'(1);
    end
  end

  always_ff @(posedge fclk) begin
    if (rst) begin
      ts_q       <= '0;
      prev_q     <= '0;
      primed_q   <= 1'b0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      ts_q       <= ts_d;
      prev_q     <= prev_d;
      primed_q   <= primed_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  ixc_sample_fifo #(
    .DW    (RW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (fclk),
    .srst      (rst),
    .push      (capture),
    .push_data ({ts_q, sv}),
    .pop       (out_ready),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (level),
    .rd_data   (out_data)
  );

  assign out_valid = !fifo_empty;
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_ixc_sample_chg_capture.sv
// Directed bench: default instance (16-bit ts, depth 16) plus a small instance
// (4-bit ts, depth 4, 2-bit drop counter) for wrap and saturation corners.
module tb_ixc_sample_chg_capture;
  import ixc_sample_pkg::*;

  logic fclk = 1'b0;
  always #5 fclk = ~fclk;

  // Instance A: default parameters
  logic        rst_a, en_a, rdy_a;
  logic [7:0]  sv_a;
  logic        valid_a, ovf_a;
  logic [23:0] data_a;
  logic [7:0]  drop_a;
  logic [4:0]  level_a;

  // Instance B: TS_W=4, DEPTH=4, DROP_W=2
  logic        rst_b, en_b, rdy_b;
  logic [7:0]  sv_b;
  logic        valid_b, ovf_b;
  logic [11:0] data_b;
  logic [1:0]  drop_b;
  logic [2:0]  level_b;

  ixc_sample_chg_capture u_dut_a (
    .fclk(fclk), .rst(rst_a), .en(en_a), .sv(sv_a),
    .out_valid(valid_a), .out_ready(rdy_a), .out_data(data_a),
    .overflow(ovf_a), .drop_cnt(drop_a), .level(level_a)
  );

  ixc_sample_chg_capture #(.WIDTH(8), .DEPTH(4), .TS_W(4), .DROP_W(2)) u_dut_b (
    .fclk(fclk), .rst(rst_b), .en(en_b), .sv(sv_b),
    .out_valid(valid_b), .out_ready(rdy_b), .out_data(data_b),
    .overflow(ovf_b), .drop_cnt(drop_b), .level(level_b)
  );

  typedef struct {
    logic        rst;
    logic        en;
    logic [7:0]  sv;
    logic        rdy;
    logic        valid;
    logic [23:0] data;
    logic        chk_data;
    logic [4:0]  level;
    logic        ovf;
    logic [7:0]  drop;
  } vec_t;

  vec_t tbl[13];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic logic [23:0] ra(input int ts, input int v);
    rec_t r;
    r.ts  = ts[15:0];
    r.val = v[7:0];
    return r;
  endfunction

  function automatic logic [11:0] rb(input int ts, input int v);
    return {ts[3:0], v[7:0]};
  endfunction

  function automatic vec_t mk(input logic r, input logic e, input logic [7:0] s, input logic rd,
                              input logic v, input logic [23:0] d, input logic cd,
                              input logic [4:0] l, input logic o, input logic [7:0] dr);
    vec_t t;
    t.rst = r; t.en = e; t.sv = s; t.rdy = rd;
    t.valid = v; t.data = d; t.chk_data = cd; t.level = l; t.ovf = o; t.drop = dr;
    return t;
  endfunction

  task automatic cyc_a(input logic r, input logic e, input logic [7:0] s, input logic rd);
    rst_a = r; en_a = e; sv_a = s; rdy_a = rd;
    @(posedge fclk);
    #1;
  endtask

  task automatic cyc_b(input logic r, input logic e, input logic [7:0] s, input logic rd);
    rst_b = r; en_b = e; sv_b = s; rdy_b = rd;
    @(posedge fclk);
    #1;
  endtask

  task automatic check_a(input string name, input logic ev, input logic [23:0] ed, input logic cd,
                         input logic [4:0] el, input logic eo, input logic [7:0] edr);
    n_vec++;
    if (valid_a !== ev || (cd && data_a !== ed) || level_a !== el || ovf_a !== eo || drop_a !== edr) begin
      n_err++;
      $display("FAIL %s: got v=%0b d=%h lvl=%0d ovf=%0b drop=%0d, want v=%0b d=%h lvl=%0d ovf=%0b drop=%0d",
               name, valid_a, data_a, level_a, ovf_a, drop_a, ev, ed, el, eo, edr);
    end else begin
      $display("ok   %s: v=%0b d=%h lvl=%0d ovf=%0b drop=%0d", name, valid_a, data_a, level_a, ovf_a, drop_a);
    end
  endtask

  task automatic check_b(input string name, input logic ev, input logic [11:0] ed, input logic cd,
                         input logic [2:0] el, input logic eo, input logic [1:0] edr);
    n_vec++;
    if (valid_b !== ev || (cd && data_b !== ed) || level_b !== el || ovf_b !== eo || drop_b !== edr) begin
      n_err++;
      $display("FAIL %s: got v=%0b d=%h lvl=%0d ovf=%0b drop=%0d, want v=%0b d=%h lvl=%0d ovf=%0b drop=%0d",
               name, valid_b, data_b, level_b, ovf_b, drop_b, ev, ed, el, eo, edr);
    end else begin
      $display("ok   %s: v=%0b d=%h lvl=%0d ovf=%0b drop=%0d", name, valid_b, data_b, level_b, ovf_b, drop_b);
    end
  endtask

  initial begin
    rst_a = 1'b1; en_a = 1'b0; sv_a = 8'h00; rdy_a = 1'b0;
    rst_b = 1'b1; en_b = 1'b0; sv_b = 8'h00; rdy_b = 1'b0;

    // Reset, one idle cycle (ts 0), then sv=00 held 5 cycles: single prime at ts=1.
    // Then A5 at ts 6 (popped next cycle), 5A at ts 8 held while ready=0.
    tbl[0]  = mk(1, 0, 8'h00, 0, 0, ra(0, 0),     1, 0, 0, 0);
    tbl[1]  = mk(0, 0, 8'h00, 0, 0, ra(0, 0),     1, 0, 0, 0);
    for (int i = 2; i <= 6; i++)
      tbl[i] = mk(0, 1, 8'h00, 0, 1, ra(1, 'h00), 1, 1, 0, 0);
    tbl[7]  = mk(0, 1, 8'hA5, 1, 1, ra(6, 'hA5),  1, 1, 0, 0);
    tbl[8]  = mk(0, 1, 8'hA5, 1, 0, 24'h0,        0, 0, 0, 0);
    tbl[9]  = mk(0, 1, 8'h5A, 0, 1, ra(8, 'h5A),  1, 1, 0, 0);
    tbl[10] = mk(0, 1, 8'h5A, 0, 1, ra(8, 'h5A),  1, 1, 0, 0);
    tbl[11] = mk(0, 1, 8'h5A, 0, 1, ra(8, 'h5A),  1, 1, 0, 0);
    tbl[12] = mk(0, 1, 8'h5A, 1, 0, 24'h0,        0, 0, 0, 0);

    for (int i = 0; i < 13; i++) begin
      cyc_a(tbl[i].rst, tbl[i].en, tbl[i].sv, tbl[i].rdy);
      check_a($sformatf("vec%0d", i), tbl[i].valid, tbl[i].data, tbl[i].chk_data,
              tbl[i].level, tbl[i].ovf, tbl[i].drop);
    end

    // Fill past full: values 1..20 at ts 12..31; last 4 dropped.
    for (int i = 0; i < 20; i++) begin
      cyc_a(0, 1, 8'(i + 1), 0);
      check_a($sformatf("fill%0d", i), 1, ra(12, 1), 1,
              (i < 16) ? 5'(i + 1) : 5'd16, (i >= 16), (i >= 16) ? 8'(i - 15) : 8'd0);
    end

    // Full with pop and push together (ts 32): level stays, nothing dropped.
    cyc_a(0, 1, 8'h77, 1);
    check_a("full_pop_push", 1, ra(13, 2), 1, 5'd16, 1, 8'd4);

    // Drain with en=0 and sv unknown: order preserved, new record at the tail.
    for (int k = 0; k < 16; k++) begin
      cyc_a(0, 0, 8'hxx, 1);
      if (k < 14)
        check_a($sformatf("drain%0d", k), 1, ra(14 + k, 3 + k), 1, 5'(15 - k), 1, 8'd4);
      else if (k == 14)
        check_a("drain14", 1, ra(32, 'h77), 1, 5'd1, 1, 8'd4);
      else
        check_a("drain15", 0, 24'h0, 0, 5'd0, 1, 8'd4);
    end

    // Queue 7 records (ts 49..55, first is a re-prime after en=0).
    for (int i = 0; i < 7; i++) begin
      cyc_a(0, 1, 8'(8'h40 + i), 0);
      check_a($sformatf("queue%0d", i), 1, ra(49, 'h40), 1, 5'(i + 1), 1, 8'd4);
    end

    // Mid-run reset discards everything; next enabled cycle re-primes at ts 0.
    cyc_a(1, 1, 8'h46, 0);
    check_a("mid_rst", 0, 24'h0, 1, 5'd0, 0, 8'd0);
    cyc_a(0, 1, 8'h46, 0);
    check_a("reprime", 1, ra(0, 'h46), 1, 5'd1, 0, 8'd0);
    cyc_a(0, 1, 8'h46, 0);
    check_a("reprime_hold", 1, ra(0, 'h46), 1, 5'd1, 0, 8'd0);

    // Instance B: prime at ts 0, free-run with no change through the ts wrap.
    cyc_b(0, 1, 8'h11, 0);
    check_b("b_prime", 1, rb(0, 'h11), 1, 3'd1, 0, 2'd0);
    for (int i = 1; i <= 17; i++) begin
      cyc_b(0, 1, 8'h11, 1);
      check_b($sformatf("b_run%0d", i), 0, 12'h0, 0, 3'd0, 0, 2'd0);
    end
    cyc_b(0, 1, 8'h22, 0);
    check_b("b_wrap", 1, rb(2, 'h22), 1, 3'd1, 0, 2'd0);

    // Fill depth 4, then 4 drops: counter sticks at 3.
    for (int i = 0; i < 7; i++) begin
      cyc_b(0, 1, 8'(8'h30 + i), 0);
      check_b($sformatf("b_fill%0d", i), 1, rb(2, 'h22), 1,
              (i < 3) ? 3'(i + 2) : 3'd4, (i >= 3), (i >= 3) ? ((i >= 5) ? 2'd3 : 2'(i - 2)) : 2'd0);
    end

    // sv equals the last dropped value: pop only, no new record.
    cyc_b(0, 1, 8'h36, 1);
    check_b("b_prev_after_drop", 1, rb(3, 'h30), 1, 3'd3, 1, 2'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
